// File: rtl/tmr_layer_engine.sv
// tmr_layer_engine
// CRC-protected fixed-point neuron layer. Each accepted beat carries one
// activation H and N CRC-protected weight codewords. Clean beats add the
// saturated product W*H >>> FRAC into each lane accumulator. A beat with any
// bad codeword is rejected and retried; too many consecutive rejects on the
// same step park the engine in FAIL until the next start.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start            frame start pulse (honoured in IDLE and FAIL only)
//   in_valid/ready   beat handshake (ready only in RUN)
//   H                signed activation for the current step
//   Wcrc             N codewords {data[n-1:0], crc[cl-1:0]}, lane 0 at LSB
//   out_valid/ready  result handshake (valid only in DONE)
//   Y                N signed accumulators, lane 0 at LSB
//   crc_err          one-cycle pulse after a rejected beat
//   lane_err         bad-lane mask of the last rejected beat
//   sat              sticky saturation flag for the current frame
//   fail             engine is in FAIL
//   fault_cnt        saturating count of rejected beats, cleared by reset only
module tmr_layer_engine #(
   parameter int N = 4,
   parameter int S = 8,
   parameter int n = 16,
   parameter int cl = 8,
   parameter logic [cl-1:0] POLY = 8'h07,
   parameter int FRAC = 8,
   parameter int MAXRETRY = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [n-1:0]          H,
   input  logic [N*(n+cl)-1:0]   Wcrc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*n-1:0]        Y,
   output logic                  crc_err,
   output logic [N-1:0]          lane_err,
   output logic                  sat,
   output logic                  fail,
   output logic [15:0]           fault_cnt
);

   localparam int SW = (S > 1) ? $clog2(S) : 1;
   localparam int RW = $clog2(MAXRETRY + 1);
   localparam logic signed [2*n-1:0] MAX_V = {{(n+1){1'b0}}, {(n-1){1'b1}}};
   localparam logic signed [2*n-1:0] MIN_V = {{(n+1){1'b1}}, {(n-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FAIL = 2'd3} state_t;

   // MSB-first CRC over the data bits, init 0.
   function automatic logic [cl-1:0] crc_calc(input logic [n-1:0] d);
      logic [cl-1:0] c;
      logic          fb;
      c = '0;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[cl-1] ^ d[i];
         c  = {c[cl-2:0], 1'b0};
         if (fb) c = c ^ POLY;
         else    c = c;
      end
      return c;
   endfunction

   // Clamp a 2n-bit signed value to n bits; MSB of the result flags a clamp.
   function automatic logic [n:0] sat_to_n(input logic signed [2*n-1:0] v);
      logic [n:0] r;
      if (v > MAX_V)      r = {1'b1, MAX_V[n-1:0]};
      else if (v < MIN_V) r = {1'b1, MIN_V[n-1:0]};
      else                r = {1'b0, v[n-1:0]};
      return r;
   endfunction

   state_t                 state_r, state_nx_s;
   logic [N-1:0][n-1:0]    acc_r, acc_nx_s;
   logic [SW-1:0]          step_r;
   logic [RW-1:0]          retry_r;
   logic [15:0]            fault_r;
   logic [N-1:0]           lane_err_r, bad_s;
   logic                   sat_r, sat_hit_s, crc_err_r;
   logic                   in_ready_r, out_valid_r, fail_r;
   logic                   beat_s, clr_s;

   logic [n-1:0]           w_data_s  [N];
   logic [cl-1:0]          w_crc_s   [N];
   logic signed [2*n-1:0]  prod_s    [N];
   logic [n:0]             prod_sat_s[N];
   logic signed [2*n-1:0]  sum_s     [N];
   logic [n:0]             sum_sat_s [N];

   assign beat_s = in_valid & in_ready_r;
   assign clr_s  = start & ((state_r == IDLE) | (state_r == FAIL));

   // Per-lane CRC check and saturating multiply-accumulate candidate.
   always_comb begin
      bad_s     = '0;
      sat_hit_s = 1'b0;
      acc_nx_s  = acc_r;
      for (int j = 0; j < N; j++) begin
         w_data_s[j]   = Wcrc[(n+cl)*(j+1)-1 -: n];
         w_crc_s[j]    = Wcrc[(n+cl)*j+cl-1 -: cl];
         bad_s[j]      = (crc_calc(w_data_s[j]) != w_crc_s[j]);
         // Sign-extend both operands so the low 2n bits hold the exact product.
         prod_s[j]     = ($signed({{n{w_data_s[j][n-1]}}, w_data_s[j]}) *
                          $signed({{n{H[n-1]}}, H})) >>> FRAC;
         prod_sat_s[j] = sat_to_n(prod_s[j]);
         sum_s[j]      = {{n{acc_r[j][n-1]}}, acc_r[j]} +
                         {{n{prod_sat_s[j][n-1]}}, prod_sat_s[j][n-1:0]};
         sum_sat_s[j]  = sat_to_n(sum_s[j]);
         acc_nx_s[j]   = sum_sat_s[j][n-1:0];
         sat_hit_s     = sat_hit_s | prod_sat_s[j][n] | sum_sat_s[j][n];
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nx_s = RUN;
            else       state_nx_s = IDLE;
         end
         RUN: begin
            if (beat_s && (|bad_s)) begin
               if (retry_r == RW'(MAXRETRY - 1)) state_nx_s = FAIL;
               else                              state_nx_s = RUN;
            end else if (beat_s && (step_r == SW'(S - 1))) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) state_nx_s = IDLE;
            else           state_nx_s = DONE;
         end
         FAIL: begin
            if (start) state_nx_s = RUN;
            else       state_nx_s = FAIL;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register and registered state-decoded handshake/status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         fail_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == RUN);
         out_valid_r <= (state_nx_s == DONE);
         fail_r      <= (state_nx_s == FAIL);
      end
   end

   // Accumulators, step/retry counters, error reporting and fault counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r      <= '0;
         step_r     <= '0;
         retry_r    <= '0;
         fault_r    <= 16'd0;
         lane_err_r <= '0;
         sat_r      <= 1'b0;
         crc_err_r  <= 1'b0;
      end else begin
         crc_err_r <= 1'b0;
         if (clr_s) begin
            acc_r      <= '0;
            step_r     <= '0;
            retry_r    <= '0;
            lane_err_r <= '0;
            sat_r      <= 1'b0;
         end else if (beat_s && (|bad_s)) begin
            crc_err_r  <= 1'b1;
            lane_err_r <= bad_s;
            retry_r    <= retry_r + RW'(1);
            fault_r    <= (fault_r == 16'hFFFF) ? fault_r : fault_r + 16'd1;
         end else if (beat_s) begin
            acc_r   <= acc_nx_s;
            step_r  <= step_r + SW'(1);
            retry_r <= '0;
            sat_r   <= sat_r | sat_hit_s;
         end else begin
            acc_r <= acc_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign fail      = fail_r;
   assign Y         = acc_r;
   assign crc_err   = crc_err_r;
   assign lane_err  = lane_err_r;
   assign sat       = sat_r;
   assign fault_cnt = fault_r;

endmodule

// File: tb/tb_tmr_layer_engine.sv
// Scoreboard bench for tmr_layer_engine: stimulus pushes expected frame
// results and expected CRC-error reports into queues; monitors pop and
// compare whenever the DUT presents a result or a crc_err pulse.
module tb_tmr_layer_engine;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int n  = 16;
   localparam int cl = 8;

   logic                 clk = 1'b0;
   logic                 reset, start, in_valid, out_ready;
   logic                 in_ready, out_valid, crc_err, sat, fail;
   logic [n-1:0]         H;
   logic [N*(n+cl)-1:0]  Wcrc;
   logic [N*n-1:0]       Y;
   logic [N-1:0]         lane_err;
   logic [15:0]          fault_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [N*n-1:0] exp_y_q[$];
   logic           exp_sat_q[$];
   logic [N-1:0]   exp_lane_q[$];
   logic [15:0]    exp_fault_q[$];

   tmr_layer_engine #(.N(N), .S(S), .n(n), .cl(cl), .POLY(8'h07), .FRAC(8), .MAXRETRY(3)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .H(H), .Wcrc(Wcrc), .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
      .crc_err(crc_err), .lane_err(lane_err), .sat(sat), .fail(fail), .fault_cnt(fault_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [15:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 15; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   function automatic logic [N*n-1:0] all_lanes(input logic [n-1:0] v);
      return {N{v}};
   endfunction

   // Result monitor and CRC-error monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_y_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_output: got Y=%h expected no output", Y);
         end else begin
            check("frame_Y", 64'(Y), 64'(exp_y_q.pop_front()));
            check("frame_sat", 64'(sat), 64'(exp_sat_q.pop_front()));
         end
      end
      if (reset === 1'b1 && crc_err === 1'b1) begin
         if (exp_lane_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_crc_err: got lane_err=%b expected no pulse", lane_err);
         end else begin
            check("lane_err", 64'(lane_err), 64'(exp_lane_q.pop_front()));
            check("fault_cnt", 64'(fault_cnt), 64'(exp_fault_q.pop_front()));
         end
      end
   end

   // Present one beat and hold it until accepted; returns at posedge+1.
   task automatic send_beat(input logic [N*n-1:0] w, input logic [n-1:0] h, input logic [N-1:0] flip);
      logic [n-1:0] d;
      bit           done;
      done = 1'b0;
      for (int j = 0; j < N; j++) begin
         d = w[n*j +: n];
         Wcrc[(n+cl)*j +: n+cl] = {d ^ {{(n-1){1'b0}}, flip[j]}, crc8(d)};
      end
      H        = h;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("FAIL beat_timeout: in_ready stayed 0 expected 1");
      end
   endtask

   task automatic run_frame(input logic [N*n-1:0] w, input logic [n-1:0] h);
      for (int s = 0; s < S; s++) send_beat(w, h, '0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (!out_valid) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("FAIL out_timeout: out_valid stayed 1 expected 0");
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      H = '0; Wcrc = '0;
      #12;
      check("rst_Y", 64'(Y), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_fail", 64'(fail), 64'd0);
      check("rst_fault_cnt", 64'(fault_cnt), 64'd0);
      check("rst_lane_err", 64'(lane_err), 64'd0);
      check("rst_sat", 64'(sat), 64'd0);
      check("rst_crc_err", 64'(crc_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_in_ready", 64'(in_ready), 64'd0);

      // Basic frame: 1.0 * 2.0 over 8 steps = 16.0 per lane.
      pulse_start();
      check("run_in_ready", 64'(in_ready), 64'd1);
      exp_y_q.push_back(all_lanes(16'h1000)); exp_sat_q.push_back(1'b0);
      run_frame(all_lanes(16'h0100), 16'h0200);
      check("out_valid_latency", 64'(out_valid), 64'd1);
      check("done_in_ready", 64'(in_ready), 64'd0);
      wait_idle();

      // Lane 2 corrupted once at step 3, then re-sent clean.
      pulse_start();
      exp_y_q.push_back(all_lanes(16'h1000)); exp_sat_q.push_back(1'b0);
      for (int s = 0; s < S; s++) begin
         if (s == 3) begin
            exp_lane_q.push_back(4'b0100); exp_fault_q.push_back(16'd1);
            send_beat(all_lanes(16'h0100), 16'h0200, 4'b0100);
         end
         send_beat(all_lanes(16'h0100), 16'h0200, 4'b0000);
      end
      wait_idle();
      check("lane_err_hold", 64'(lane_err), 64'(4'b0100));

      // Reset in IDLE clears fault_cnt; then step 5 fails three times.
      reset = 1'b0;
      #1;
      check("rst_idle_fault_cnt", 64'(fault_cnt), 64'd0);
      check("rst_idle_lane_err", 64'(lane_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      pulse_start();
      for (int s = 0; s < 5; s++) send_beat(all_lanes(16'h0100), 16'h0200, 4'b0000);
      for (int r = 1; r <= 3; r++) begin
         exp_lane_q.push_back(4'b0001); exp_fault_q.push_back(16'(r));
         send_beat(all_lanes(16'h0100), 16'h0200, 4'b0001);
      end
      check("fail_set", 64'(fail), 64'd1);
      check("fail_in_ready", 64'(in_ready), 64'd0);
      check("fail_out_valid", 64'(out_valid), 64'd0);
      check("fail_fault_cnt", 64'(fault_cnt), 64'd3);
      check("fail_Y_frozen", 64'(Y), 64'(all_lanes(16'h0A00)));
      repeat (3) @(posedge clk);
      #1;
      check("fail_hold", 64'(fail), 64'd1);
      pulse_start();
      check("fail_cleared", 64'(fail), 64'd0);
      check("restart_in_ready", 64'(in_ready), 64'd1);
      check("restart_Y_clear", 64'(Y), 64'd0);
      exp_y_q.push_back(all_lanes(16'h1000)); exp_sat_q.push_back(1'b0);
      run_frame(all_lanes(16'h0100), 16'h0200);
      wait_idle();

      // Saturation: max * max clamps every lane; next frame clears sat.
      pulse_start();
      exp_y_q.push_back(all_lanes(16'h7FFF)); exp_sat_q.push_back(1'b1);
      run_frame(all_lanes(16'h7FFF), 16'h7FFF);
      wait_idle();
      pulse_start();
      check("sat_cleared_on_start", 64'(sat), 64'd0);
      exp_y_q.push_back(all_lanes(16'h1000)); exp_sat_q.push_back(1'b0);
      run_frame(all_lanes(16'h0100), 16'h0200);
      wait_idle();

      // Back-pressure in DONE with mixed-sign lanes; start must be ignored.
      out_ready = 1'b0;
      pulse_start();
      exp_y_q.push_back({16'h3000, 16'h0800, 16'hF000, 16'h1000}); exp_sat_q.push_back(1'b0);
      run_frame({16'h0300, 16'h0080, 16'hFF00, 16'h0100}, 16'h0200);
      for (int k = 0; k < 10; k++) begin
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_Y", 64'(Y), 64'({16'h3000, 16'h0800, 16'hF000, 16'h1000}));
         start = (k == 4) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", 64'(out_valid), 64'd0);
      check("release_in_ready", 64'(in_ready), 64'd0);

      // Reset mid-frame discards partial sums.
      pulse_start();
      for (int s = 0; s < 4; s++) send_beat(all_lanes(16'h0100), 16'h0200, 4'b0000);
      reset = 1'b0;
      #2;
      check("midrst_Y", 64'(Y), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      exp_y_q.push_back(all_lanes(16'hF000)); exp_sat_q.push_back(1'b0);
      run_frame(all_lanes(16'h0200), 16'hFF00);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      check("frames_outstanding", 64'(exp_y_q.size()), 64'd0);
      check("crc_reports_outstanding", 64'(exp_lane_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
